// File: rtl/vend_pkg.sv
// Shared constants for the vending-machine front-end sequencer: state encoding,
// default timing parameters and datapath widths.
package vend_pkg;

    localparam int CREDIT_W = 3;
    localparam int PROD_W   = 3;
    localparam int STATE_W  = 3;
    localparam int TIMER_W  = 8;
    localparam int DB_CNT_W = 4;

    localparam int DEF_DB_CYCLES    = 4;
    localparam int DEF_ACC_TIMEOUT  = 16;
    localparam int DEF_DISP_TIMEOUT = 32;
    localparam int DEF_PRICE        = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_ACC = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHECK    = 3'd2;
    localparam logic [STATE_W-1:0] ST_DISPENSE = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT    = 3'd5;

    typedef logic [TIMER_W-1:0] timer_t;

    function automatic timer_t timer_sat_inc(input timer_t t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

endpackage

// File: rtl/vend_debounce.sv
// Pad conditioner: 2-flop synchronizer, consecutive-cycle debounce counter and a
// single-cycle event on the debounced rising edge.
module vend_debounce
    import vend_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic evt
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic                sync_q1;
    logic                sync_q2;
    logic                level_q;
    logic                level_prev_q;
    logic [DB_CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so the synchronizer stages and
    // the counter all see pre-edge values; blocking here would collapse the flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1      <= 1'b0;
            sync_q2      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else if (ena) begin
            sync_q1      <= raw;
            sync_q2      <= sync_q1;
            level_prev_q <= level_q;
            if (sync_q2 != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q2;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // Gated so a frozen rising edge cannot be seen on every stalled cycle.
    assign evt = ena & level_q & ~level_prev_q;

endmodule

// File: rtl/vend_seq_ctrl.sv
// Front-end sequencer for the vending-machine FSM: turns debounced pad events into
// m/a/d strobes and runs the accept and dispense handshakes with timeouts.
module vend_seq_ctrl
    import vend_pkg::*;
#(
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int ACC_TIMEOUT  = DEF_ACC_TIMEOUT,
    parameter int DISP_TIMEOUT = DEF_DISP_TIMEOUT,
    parameter int PRICE        = DEF_PRICE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                coin_raw,
    input  logic                accept_raw,
    input  logic                cancel_raw,
    input  logic [CREDIT_W-1:0] credit_i,
    input  logic [PROD_W-1:0]   prod_i,
    output logic                m_o,
    output logic                a_o,
    output logic                d_o,
    output logic                clr_o,
    output logic                rej_o,
    output logic                done_o,
    output logic                err_o,
    output logic [STATE_W-1:0]  state_o
);

    // The timer holds the number of cycles already spent waiting, so the last
    // allowed waiting cycle is the one where it equals TIMEOUT-1.
    localparam timer_t              ACC_LAST  = timer_t'(ACC_TIMEOUT - 1);
    localparam timer_t              DISP_LAST = timer_t'(DISP_TIMEOUT - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

    logic               coin_evt;
    logic               accept_evt;
    logic               cancel_evt;
    logic [STATE_W-1:0] state;
    timer_t             timer;
    logic               acc_pend;
    logic               m_q;
    logic               a_q;
    logic               rej_q;
    logic               done_q;
    logic               clr_q;
    logic               d_q;
    logic               err_q;

    vend_debounce #(.DB_CYCLES(DB_CYCLES)) u_coin_db (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .raw (coin_raw),
        .evt (coin_evt)
    );

    vend_debounce #(.DB_CYCLES(DB_CYCLES)) u_accept_db (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .raw (accept_raw),
        .evt (accept_evt)
    );

    vend_debounce #(.DB_CYCLES(DB_CYCLES)) u_cancel_db (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .raw (cancel_raw),
        .evt (cancel_evt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            acc_pend <= 1'b0;
            m_q      <= 1'b0;
            a_q      <= 1'b0;
            rej_q    <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            d_q      <= 1'b0;
            err_q    <= 1'b0;
        end else if (ena) begin
            m_q      <= 1'b0;
            a_q      <= 1'b0;
            rej_q    <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            acc_pend <= 1'b0;

            if (state == ST_WAIT_ACC || state == ST_DISPENSE)
                timer <= timer_sat_inc(timer);

            // Only one coin may be outstanding; any other coin is bounced.
            if (coin_evt && (state != ST_IDLE || cancel_evt))
                rej_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cancel_evt) begin
                        clr_q <= 1'b1;
                    end else if (coin_evt) begin
                        m_q   <= 1'b1;
                        timer <= '0;
                        state <= ST_WAIT_ACC;
                    end
                end

                ST_WAIT_ACC: begin
                    // a_o goes out one cycle before CHECK so credit_i has settled there.
                    if (acc_pend) begin
                        state <= ST_CHECK;
                    end else if (cancel_evt) begin
                        clr_q <= 1'b1;
                        state <= ST_IDLE;
                    end else if (accept_evt) begin
                        a_q      <= 1'b1;
                        acc_pend <= 1'b1;
                    end else if (timer >= ACC_LAST) begin
                        rej_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                end

                ST_CHECK: begin
                    if (credit_i >= PRICE_C) begin
                        d_q   <= 1'b1;
                        timer <= '0;
                        state <= ST_DISPENSE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_DISPENSE: begin
                    if (prod_i != '0) begin
                        d_q    <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else if (timer >= DISP_LAST) begin
                        d_q   <= 1'b0;
                        err_q <= 1'b1;
                        clr_q <= 1'b1;
                        state <= ST_FAULT;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                ST_FAULT: begin
                    if (cancel_evt) begin
                        err_q <= 1'b0;
                        clr_q <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        clr_q <= 1'b1;
                    end
                end

                default: begin
                    d_q   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_o     = m_q & ena;
    assign a_o     = a_q & ena;
    assign rej_o   = rej_q & ena;
    assign done_o  = done_q & ena;
    // In FAULT clr_o is a held level, not a pulse, so it survives ena=0.
    assign clr_o   = clr_q & (ena | err_q);
    assign d_o     = d_q;
    assign err_o   = err_q;
    assign state_o = state;

endmodule
